// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the register-file write port.
// Registers ALU results for a one-cycle write. For loads, it waits for
// the LSU response, then extracts and extends the load data.
//
// Parameters:
//   TIMEOUT_CYCLES - load-response timeout in cycles (2..1024). It only
//                    has an effect when WB_LOAD_TIMEOUT_EN is defined.
//
// Optional feature:
//   `define WB_LOAD_TIMEOUT_EN enables the load-response timeout.
//
// Ports:
//   clk, resetn    - clock; synchronous active-low reset
//   ex_valid/ready - retiring-instruction handshake from execute
//   ex_we, ex_rd   - destination write enable and index
//   ex_result      - ALU/CSR result for non-loads
//   ex_is_load     - instruction is a load
//   ex_load_type   - load funct3
//   ex_addr_lo     - load address bits [1:0]
//   data_rvalid    - LSU response valid (single-cycle pulse)
//   data_rdata     - raw aligned word from memory
//   data_err       - bus error, qualified by data_rvalid
//   reg_write, rd, write_data - register-file write port
//   load_pending   - a load is outstanding
//   pending_rd     - destination of the outstanding load (0 if none)
//   load_err       - one-cycle pulse on load bus error or timeout
module wb_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_we,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_load_type,
    input  logic [1:0]  ex_addr_lo,
    input  logic        data_rvalid,
    input  logic [31:0] data_rdata,
    input  logic        data_err,
    output logic        reg_write,
    output logic [4:0]  rd,
    output logic [31:0] write_data,
    output logic        load_pending,
    output logic [4:0]  pending_rd,
    output logic        load_err
);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_e;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1024) begin : g_bad_timeout
        $error("wb_stage: TIMEOUT_CYCLES must be in 2..1024");
    end

    state_e      state_q, state_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [2:0]  ld_type_q, ld_type_d;
    logic [1:0]  ld_addr_q, ld_addr_d;
    logic        ld_we_q, ld_we_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wdata_q, wdata_d;
    logic        load_err_q, load_err_d;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Halfword lane uses addr[1] only; the LSU guarantees alignment.
    function automatic logic [31:0] extract(
        input logic [2:0]  ltype,
        input logic [1:0]  alo,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{alo, 3'b000} +: 8];
        h = alo[1] ? word[31:16] : word[15:0];
        unique case (ltype)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_type_d   = ld_type_q;
        ld_addr_d   = ld_addr_q;
        ld_we_d     = ld_we_q;
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        load_err_d  = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_is_load) begin
                        ld_rd_d   = ex_rd;
                        ld_type_d = ex_load_type;
                        ld_addr_d = ex_addr_lo;
                        ld_we_d   = ex_we;
                        state_d   = WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end else if (ex_we) begin
                        reg_write_d = (ex_rd != 5'd0);
                        rd_d        = ex_rd;
                        wdata_d     = ex_result;
                    end
                end
            end
            WAIT_LOAD: begin
                if (data_rvalid) begin
                    state_d = IDLE;
                    if (data_err) begin
                        load_err_d = 1'b1;
                    end else if (ld_we_q) begin
                        reg_write_d = (ld_rd_q != 5'd0);
                        rd_d        = ld_rd_q;
                        wdata_d     = extract(ld_type_q, ld_addr_q,
                                              data_rdata);
                    end
                end
`ifdef WB_LOAD_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    load_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ld_rd_q     <= 5'd0;
            ld_type_q   <= 3'd0;
            ld_addr_q   <= 2'd0;
            ld_we_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            wdata_q     <= 32'd0;
            load_err_q  <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_type_q   <= ld_type_d;
            ld_addr_q   <= ld_addr_d;
            ld_we_q     <= ld_we_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            load_err_q  <= load_err_d;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign ex_ready     = (state_q == IDLE);
    assign load_pending = (state_q == WAIT_LOAD);
    assign pending_rd   = (state_q == WAIT_LOAD) ? ld_rd_q : 5'd0;
    assign reg_write    = reg_write_q;
    assign rd           = rd_q;
    assign write_data   = wdata_q;
    assign load_err     = load_err_q;

endmodule
